// File: rtl/demux_dest_fifo.sv
// Routes a valid/data stream into two destination FIFOs selected by one data bit,
// with almost-full pause feedback, run-time thresholds and a sticky overflow flag.

module demux_dest_fifo_buf #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W:0]   af_thr,
    input  logic [ADDR_W:0]   ae_thr,
    output logic [DATA_W-1:0] dout,
    output logic              vout,
    output logic              empty,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              empty_next
);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_nxt;
    logic              full, rd_ok, wr_ok;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign full     = (count == FULL_CNT);
    assign rd_ok    = pop && (count != '0);
    assign wr_ok    = push && (!full || rd_ok);
    assign overflow = push && full && !rd_ok;

    // NOTE: every comb output gets a default first, so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + CNT_ONE;
        else if (rd_ok && !wr_ok)
            count_nxt = count - CNT_ONE;
    end

    assign empty_next   = (count_nxt == '0);
    assign empty        = (count == '0);
    assign almost_empty = (count <= ae_thr);
    assign almost_full  = (count >= af_thr);

    // NOTE: storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            vout   <= 1'b0;
        end else begin
            count <= count_nxt;
            vout  <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr];
            end
        end
    end
endmodule

module demux_dest_fifo #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int DEST_BIT = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [ADDR_W:0]   umbral_af,
    input  logic [ADDR_W:0]   umbral_ae,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_d0,
    input  logic              pop_d1,
    output logic [DATA_W-1:0] data_out_d0,
    output logic [DATA_W-1:0] data_out_d1,
    output logic              valid_out_d0,
    output logic              valid_out_d1,
    output logic              empty_d0,
    output logic              empty_d1,
    output logic              almost_empty_d0,
    output logic              almost_empty_d1,
    output logic              almost_full_d0,
    output logic              almost_full_d1,
    output logic              pause,
    output logic              error_out,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] AF_RST = (ADDR_W+1)'(DEPTH - 2);
    localparam logic [ADDR_W:0] AE_RST = (ADDR_W+1)'(1);

    state_t          state_q, state_nxt;
    logic [ADDR_W:0] af_q, ae_q;
    logic            error_q;
    logic            accept, thr_load, push_any, push_d0, push_d1;
    logic            ovf_d0, ovf_d1, empty_next_d0, empty_next_d1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            state_q <= S_RESET;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_RESET: state_nxt = S_INIT;
            S_INIT:  if (!init) state_nxt = S_IDLE;
            S_IDLE: begin
                if (ovf_d0 || ovf_d1)  state_nxt = S_ERROR;
                else if (init)         state_nxt = S_INIT;
                else if (push_any)     state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf_d0 || ovf_d1)                  state_nxt = S_ERROR;
                else if (init)                         state_nxt = S_INIT;
                else if (empty_next_d0 && empty_next_d1) state_nxt = S_IDLE;
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        thr_load = 1'b0;
        unique case (state_q)
            S_INIT:                     thr_load = init;
            S_IDLE, S_ACTIVE, S_ERROR:  accept   = 1'b1;
            default: ;
        endcase
    end

    assign push_any = accept && valid_in;
    assign push_d0  = push_any && !data_in[DEST_BIT];
    assign push_d1  = push_any &&  data_in[DEST_BIT];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            af_q    <= AF_RST;
            ae_q    <= AE_RST;
            error_q <= 1'b0;
        end else begin
            if (thr_load) begin
                af_q <= umbral_af;
                ae_q <= umbral_ae;
            end
            if (ovf_d0 || ovf_d1)
                error_q <= 1'b1;
        end
    end

    demux_dest_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo_d0 (
        .clk(clk), .reset_L(reset_L), .push(push_d0), .pop(pop_d0), .din(data_in),
        .af_thr(af_q), .ae_thr(ae_q), .dout(data_out_d0), .vout(valid_out_d0),
        .empty(empty_d0), .almost_empty(almost_empty_d0), .almost_full(almost_full_d0),
        .overflow(ovf_d0), .empty_next(empty_next_d0)
    );

    demux_dest_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo_d1 (
        .clk(clk), .reset_L(reset_L), .push(push_d1), .pop(pop_d1), .din(data_in),
        .af_thr(af_q), .ae_thr(ae_q), .dout(data_out_d1), .vout(valid_out_d1),
        .empty(empty_d1), .almost_empty(almost_empty_d1), .almost_full(almost_full_d1),
        .overflow(ovf_d1), .empty_next(empty_next_d1)
    );

    assign pause     = almost_full_d0 | almost_full_d1;
    assign error_out = error_q;
    assign state     = state_q;
endmodule

// File: tb/tb_demux_dest_fifo.sv
// Bench for demux_dest_fifo: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.

module tb_demux_dest_fifo;
    localparam int DATA_W = 10;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_L = 1'b1;
    logic              init = 1'b0;
    logic [ADDR_W:0]   umbral_af = '0;
    logic [ADDR_W:0]   umbral_ae = '0;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              pop_d0 = 1'b0;
    logic              pop_d1 = 1'b0;
    logic [DATA_W-1:0] data_out_d0, data_out_d1;
    logic              valid_out_d0, valid_out_d1, empty_d0, empty_d1;
    logic              almost_empty_d0, almost_empty_d1, almost_full_d0, almost_full_d1;
    logic              pause, error_out;
    logic [2:0]        state;

    demux_dest_fifo dut (
        .clk(clk), .reset_L(reset_L), .init(init), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
        .valid_in(valid_in), .data_in(data_in), .pop_d0(pop_d0), .pop_d1(pop_d1),
        .data_out_d0(data_out_d0), .data_out_d1(data_out_d1),
        .valid_out_d0(valid_out_d0), .valid_out_d1(valid_out_d1),
        .empty_d0(empty_d0), .empty_d1(empty_d1),
        .almost_empty_d0(almost_empty_d0), .almost_empty_d1(almost_empty_d1),
        .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
        .pause(pause), .error_out(error_out), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two queues plus the control-state rules.
    logic [DATA_W-1:0] q0[$], q1[$];
    int                m_state, m_af, m_ae;
    logic [DATA_W-1:0] m_dout0, m_dout1;
    bit                m_vout0, m_vout1, m_err;

    function void m_reset();
        q0.delete();
        q1.delete();
        m_state = 0;
        m_af    = DEPTH - 2;
        m_ae    = 1;
        m_dout0 = '0;
        m_dout1 = '0;
        m_vout0 = 1'b0;
        m_vout1 = 1'b0;
        m_err   = 1'b0;
    endfunction

    function void m_step();
        bit acc;
        bit ovf;
        acc = (m_state == 2) || (m_state == 3) || (m_state == 4);
        ovf = 1'b0;
        m_vout0 = 1'b0;
        m_vout1 = 1'b0;
        if (pop_d0 && q0.size() > 0) begin
            m_dout0 = q0.pop_front();
            m_vout0 = 1'b1;
        end
        if (pop_d1 && q1.size() > 0) begin
            m_dout1 = q1.pop_front();
            m_vout1 = 1'b1;
        end
        if (acc && valid_in) begin
            if (!data_in[8]) begin
                if (q0.size() < DEPTH) q0.push_back(data_in);
                else ovf = 1'b1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back(data_in);
                else ovf = 1'b1;
            end
        end
        if (ovf) m_err = 1'b1;
        case (m_state)
            0: m_state = 1;
            1: begin
                if (init) begin
                    m_af = int'(umbral_af);
                    m_ae = int'(umbral_ae);
                end else begin
                    m_state = 2;
                end
            end
            2, 3: begin
                if (ovf)                                             m_state = 4;
                else if (init)                                       m_state = 1;
                else if (m_state == 2 && valid_in)                   m_state = 3;
                else if (m_state == 3 && q0.size() == 0 && q1.size() == 0) m_state = 2;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) m_reset();
        else          m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", state, m_state);
            check("data_out_d0", data_out_d0, m_dout0);
            check("data_out_d1", data_out_d1, m_dout1);
            check("valid_out_d0", valid_out_d0, m_vout0);
            check("valid_out_d1", valid_out_d1, m_vout1);
            check("empty_d0", empty_d0, q0.size() == 0);
            check("empty_d1", empty_d1, q1.size() == 0);
            check("almost_empty_d0", almost_empty_d0, q0.size() <= m_ae);
            check("almost_empty_d1", almost_empty_d1, q1.size() <= m_ae);
            check("almost_full_d0", almost_full_d0, q0.size() >= m_af);
            check("almost_full_d1", almost_full_d1, q1.size() >= m_af);
            check("pause", pause, (q0.size() >= m_af) || (q1.size() >= m_af));
            check("error_out", error_out, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [DATA_W-1:0] drain_exp [8];

    initial begin
        m_reset();
        drain_exp = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h0FF};

        // Reset values and threshold load
        #3 reset_L = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_empty_d0", empty_d0, 1);
        check("rst_ae_d1", almost_empty_d1, 1);
        check("rst_pause", pause, 0);
        check("rst_error", error_out, 0);
        tick();
        tick();
        reset_L = 1'b1;
        tick();
        check("t1_to_init", state, 1);
        init = 1'b1; umbral_af = 4'd6; umbral_ae = 4'd2;
        tick();
        check("t1_hold_init", state, 1);
        init = 1'b0;
        tick();
        check("t1_idle", state, 2);
        check("t1_af_idle", almost_full_d0, 0);

        // Routing by destination bit
        valid_in = 1'b1; data_in = 10'h0A5;
        tick();
        check("t2_active", state, 3);
        data_in = 10'h1A5;
        tick();
        check("t2_d1_filled", empty_d1, 0);
        valid_in = 1'b0; pop_d0 = 1'b1; pop_d1 = 1'b1;
        tick();
        check("t2_dout0", data_out_d0, 10'h0A5);
        check("t2_dout1", data_out_d1, 10'h1A5);
        check("t2_vout0", valid_out_d0, 1);
        check("t2_back_idle", state, 2);
        pop_d0 = 1'b0; pop_d1 = 1'b0;
        tick();
        check("t2_vout0_drop", valid_out_d0, 0);
        check("t2_dout0_hold", data_out_d0, 10'h0A5);

        // Fill d0 to full, almost-full on the 6th word
        valid_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = 10'(i);
            tick();
            if (i == 5) check("t3_af_before", almost_full_d0, 0);
            if (i == 6) begin
                check("t3_af_at6", almost_full_d0, 1);
                check("t3_pause_at6", pause, 1);
                check("t3_d1_af", almost_full_d1, 0);
            end
        end
        check("t3_full_nonempty", empty_d0, 0);

        // Full: push and pop together keep count, no error
        data_in = 10'h0FF; pop_d0 = 1'b1;
        tick();
        check("t5_full_pp_dout", data_out_d0, 10'h001);
        check("t5_full_pp_err", error_out, 0);
        check("t5_full_pp_state", state, 3);

        // Full: push without pop overflows
        pop_d0 = 1'b0; data_in = 10'h011;
        tick();
        check("t4_error", error_out, 1);
        check("t4_state_err", state, 4);
        valid_in = 1'b0; pop_d0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t4_drain%0d", i), data_out_d0, drain_exp[i]);
        end
        tick();
        check("t4_pop_empty_v", valid_out_d0, 0);
        check("t4_pop_empty_hold", data_out_d0, 10'h0FF);

        // Empty: push and pop together, no fall-through
        valid_in = 1'b1; data_in = 10'h033;
        tick();
        check("t5_empty_pp_v", valid_out_d0, 0);
        check("t5_empty_pp_cnt", empty_d0, 0);
        valid_in = 1'b0;
        tick();
        check("t5_empty_pp_dout", data_out_d0, 10'h033);
        pop_d0 = 1'b0;

        // Pointer wrap with interleaved pops, then reset mid-stream
        valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 10'h040 + 10'(i);
            pop_d0  = (i % 2) == 1;
            tick();
        end
        data_in = 10'h04A; pop_d0 = 1'b1;
        #2 reset_L = 1'b0;
        #1;
        check("t6_rst_state", state, 0);
        check("t6_rst_empty", empty_d0, 1);
        check("t6_rst_dout", data_out_d0, 0);
        check("t6_rst_err", error_out, 0);
        valid_in = 1'b0; pop_d0 = 1'b0;
        tick();
        reset_L = 1'b1; valid_in = 1'b1; data_in = 10'h055;
        tick();
        tick();
        check("t6_ignored_push", empty_d0, 1);
        valid_in = 1'b0; pop_d0 = 1'b1;
        tick();
        check("t6_pop_after_rst", valid_out_d0, 0);

        // Independent destinations in the same cycle
        pop_d0 = 1'b0; valid_in = 1'b1; data_in = 10'h155;
        tick();
        data_in = 10'h066; pop_d1 = 1'b1;
        tick();
        check("t6_indep_dout1", data_out_d1, 10'h155);
        check("t6_indep_d0", empty_d0, 0);
        valid_in = 1'b0; pop_d1 = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
